mlsib_key_ctrl: RTL and testbench
=================================

// Module: mlsib_key_ctrl
// PURPOSE
//  Key-check controller that produces CompOut for one locking SIB.
//  Sits in the scan path just ahead of the SIB, snooping the key bits shifted into a private key segment.
//  Grants open only when the shifted key equals KEY_VAL.
//  Rate-limits brute force: cooldown after MAX_FAIL bad attempts, permanent block after MAX_LOCKOUT cooldowns.
// PARAMETERS
//  KEY_W        16        key length in bits
//  KEY_VAL      16'hA5C3  expected key, KEY_W bits
//  MAX_FAIL     3         consecutive failed attempts that trigger a cooldown (>=1)
//  LOCKOUT_CYC  256       cooldown length in Clock cycles (>=1)
//  MAX_LOCKOUT  2         cooldowns before permanent BLOCKED (>=1)
// PORTS
//  Clock      in   1                        scan clock, rising edge
//  RstBar     in   1                        asynchronous reset, active-low
//  SI         in   1                        scan data in
//  ShiftEN    in   1                        shift phase
//  CaptureEN  in   1                        capture phase
//  UpdateEn   in   1                        update phase
//  Select     in   1                        key segment selected
//  SO         out  1                        scan data out = kreg[0]
//  CompOut    out  1                        key match, to the SIB CompOut input
//  Locked     out  1                        high in COOLDOWN or BLOCKED
//  FailCnt    out  $clog2(MAX_FAIL+1)       failed attempts in the current window
// BEHAVIOUR
//  Reset (RstBar=0, async)
//   - kreg=0, scnt=0, CompOut=0, FailCnt=0, lock count=0, timer=0.
//   - state=ARMED, Locked=0, SO=0.
//  Phase priority per cycle (gated by Select): UpdateEn > CaptureEN > ShiftEN. Lower-priority phases are ignored.
//  Capture
//   - kreg<=0, scnt<=0. The key is never captured back onto the chain.
//  Shift
//   - kreg <= {SI, kreg[KEY_W-1:1]}.
//   - scnt increments and saturates at KEY_W+1. Over-length shifts are invalid.
//  Match
//   - match = (state==ARMED) & (scnt==KEY_W) & (kreg==KEY_VAL).
//   - CompOut is the registered match. It is valid one cycle after the last shift and is held stable through the UpdateEn cycle.
//  Update (Select&UpdateEn, ARMED)
//   - CompOut=1 (success): FailCnt<=0.
//   - CompOut=0 and scnt!=0 (failed attempt): FailCnt+1.
//   - scnt==0: no attempt, not counted. This lets the SIB be closed without a key.
//   - In every case kreg<=0 and scnt<=0 at the end of the cycle, so a key cannot be replayed.
//  FSM
//   - ARMED->COOLDOWN: failure that makes FailCnt==MAX_FAIL. Timer<=LOCKOUT_CYC-1, lock count+1.
//   - COOLDOWN: CompOut forced 0; shift/capture still move kreg (SO stays valid); updates are not counted. Timer decrements every cycle.
//   - COOLDOWN->ARMED: timer==0, FailCnt<=0.
//   - COOLDOWN->BLOCKED: entry when lock count==MAX_LOCKOUT.
//   - BLOCKED: CompOut=0 and Locked=1 until RstBar. Terminal state.
//  Reset mid-cooldown returns to ARMED with all counters 0.
//  Outputs have no combinational path from inputs. CompOut is a flop; SO is kreg[0].
// TESTING
//  T1 Reset, capture, shift KEY_VAL LSB-first (16 cycles), update
//     -> CompOut=1 on the cycle after shift 16 and during update; FailCnt=0; CompOut=0 after update.
//  T2 Shift 16'h0000 and update, three times
//     -> FailCnt 1,2 then COOLDOWN; Locked=1; FailCnt=3.
//  T3 Continue from T2, shift KEY_VAL during cooldown
//     -> CompOut stays 0; after 256 cycles ARMED, Locked=0, FailCnt=0; KEY_VAL then yields CompOut=1.
//  T4 Two full cooldown cycles (6 bad keys)
//     -> BLOCKED; KEY_VAL never yields CompOut=1; only RstBar pulse restores ARMED.
//  T5 Shift KEY_VAL plus 1 extra bit, or 15 bits
//     -> CompOut=0; update counts as a failure.
//  T6 Update with no prior shift; also ShiftEN with Select=0; also UpdateEn&ShiftEN together
//     -> FailCnt unchanged; kreg unchanged when unselected; update wins and shift is ignored.

Source files
------------

// File: rtl/mlsib_key_ctrl.sv
// Key-check controller for a locking SIB: snoops a private key segment, raises CompOut on a
// correct key and rate-limits brute force with cooldowns and a terminal block.
module mlsib_key_ctrl #(
  parameter int unsigned      KEY_W       = 16,
  parameter logic [KEY_W-1:0] KEY_VAL     = 16'hA5C3,
  parameter int unsigned      MAX_FAIL    = 3,
  parameter int unsigned      LOCKOUT_CYC = 256,
  parameter int unsigned      MAX_LOCKOUT = 2
) (
  input  logic                            Clock,
  input  logic                            RstBar,
  input  logic                            SI,
  input  logic                            ShiftEN,
  input  logic                            CaptureEN,
  input  logic                            UpdateEn,
  input  logic                            Select,
  output logic                            SO,
  output logic                            CompOut,
  output logic                            Locked,
  output logic [$clog2(MAX_FAIL+1)-1:0]   FailCnt
);

  localparam int unsigned SW = $clog2(KEY_W + 2);
  localparam int unsigned FW = $clog2(MAX_FAIL + 1);
  localparam int unsigned LW = $clog2(MAX_LOCKOUT + 1);
  localparam int unsigned TW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

  localparam logic [SW-1:0] SCNT_FULL  = SW'(KEY_W);
  localparam logic [SW-1:0] SCNT_SAT   = SW'(KEY_W + 1);
  localparam logic [FW-1:0] FAIL_LAST  = FW'(MAX_FAIL - 1);
  localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_FAIL);
  localparam logic [LW-1:0] LOCK_MAX   = LW'(MAX_LOCKOUT);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCKOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_ARMED    = 2'd0,
    ST_COOLDOWN = 2'd1,
    ST_BLOCKED  = 2'd2
  } state_t;

  state_t           state_q;
  logic [KEY_W-1:0] kreg_q, kreg_d;
  logic [SW-1:0]    scnt_q, scnt_d;
  logic [FW-1:0]    fail_q;
  logic [LW-1:0]    lock_cnt_q;
  logic [TW-1:0]    timer_q;
  logic             comp_q;
  logic             locked_q;

  logic upd, cap, shf, match;

  // Phase priority: update beats capture beats shift, all gated by Select.
  assign upd = Select & UpdateEn;
  assign cap = Select & CaptureEN & ~UpdateEn;
  assign shf = Select & ShiftEN & ~UpdateEn & ~CaptureEN;

  assign match = (state_q == ST_ARMED) && (scnt_q == SCNT_FULL) && (kreg_q == KEY_VAL);

  always_comb begin
    kreg_d = kreg_q;
    scnt_d = scnt_q;
    if (upd || cap) begin
      kreg_d = '0;
      scnt_d = '0;
    end else if (shf) begin
      kreg_d = {SI, kreg_q[KEY_W-1:1]};
      if (scnt_q != SCNT_SAT) begin
        scnt_d = scnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge RstBar) begin
    if (!RstBar) begin
      kreg_q <= '0;
      scnt_q <= '0;
    end else begin
      kreg_q <= kreg_d;
      scnt_q <= scnt_d;
    end
  end

  // CompOut drops on the update edge itself since the key is flushed on that same edge.
  always_ff @(posedge Clock or negedge RstBar) begin
    if (!RstBar) begin
      state_q    <= ST_ARMED;
      fail_q     <= '0;
      lock_cnt_q <= '0;
      timer_q    <= '0;
      comp_q     <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      comp_q <= match & ~upd;
      case (state_q)
        ST_ARMED: begin
          if (upd) begin
            if (comp_q) begin
              fail_q <= '0;
            end else if (scnt_q != '0) begin
              if (fail_q == FAIL_LAST) begin
                fail_q     <= FAIL_MAX;
                state_q    <= ST_COOLDOWN;
                locked_q   <= 1'b1;
                timer_q    <= TIMER_LOAD;
                lock_cnt_q <= lock_cnt_q + 1'b1;
              end else begin
                fail_q <= fail_q + 1'b1;
              end
            end
          end
        end
        ST_COOLDOWN: begin
          if (timer_q == '0) begin
            if (lock_cnt_q == LOCK_MAX) begin
              state_q <= ST_BLOCKED;
            end else begin
              state_q  <= ST_ARMED;
              locked_q <= 1'b0;
              fail_q   <= '0;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        ST_BLOCKED: begin
          locked_q <= 1'b1;
        end
        default: begin
          state_q  <= ST_BLOCKED;
          locked_q <= 1'b1;
        end
      endcase
    end
  end

  assign SO      = kreg_q[0];
  assign CompOut = comp_q;
  assign Locked  = locked_q;
  assign FailCnt = fail_q;

endmodule

// File: tb/tb_mlsib_key_ctrl.sv
// Bench for mlsib_key_ctrl: directed scenarios plus random traffic, checked every cycle
// against a queue-based behavioural model.
module tb_mlsib_key_ctrl;

  localparam int unsigned      KEY_W       = 16;
  localparam logic [KEY_W-1:0] KEY         = 16'hA5C3;
  localparam int unsigned      MAX_FAIL    = 3;
  localparam int unsigned      LOCKOUT_CYC = 256;
  localparam int unsigned      MAX_LOCKOUT = 2;

  logic       Clock = 1'b0;
  logic       RstBar = 1'b0;
  logic       SI = 1'b0, ShiftEN = 1'b0, CaptureEN = 1'b0, UpdateEn = 1'b0, Select = 1'b0;
  logic       SO, CompOut, Locked;
  logic [1:0] FailCnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc_cnt  = 0;

  mlsib_key_ctrl #(
    .KEY_W      (KEY_W),
    .KEY_VAL    (KEY),
    .MAX_FAIL   (MAX_FAIL),
    .LOCKOUT_CYC(LOCKOUT_CYC),
    .MAX_LOCKOUT(MAX_LOCKOUT)
  ) dut (
    .Clock    (Clock),
    .RstBar   (RstBar),
    .SI       (SI),
    .ShiftEN  (ShiftEN),
    .CaptureEN(CaptureEN),
    .UpdateEn (UpdateEn),
    .Select   (Select),
    .SO       (SO),
    .CompOut  (CompOut),
    .Locked   (Locked),
    .FailCnt  (FailCnt)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The key segment is kept as the list of bits shifted since the last flush;
  // the segment contents are the most recent KEY_W of them.
  typedef enum {M_ARMED, M_COOL, M_BLOCK} mmode_t;
  bit          mq[$];
  mmode_t      m_mode   = M_ARMED;
  int unsigned m_fails  = 0;
  int unsigned m_cd     = 0;
  int unsigned m_cdleft = 0;
  bit          m_comp   = 1'b0;

  function automatic logic [KEY_W-1:0] mkey();
    logic [KEY_W-1:0] v;
    int base;
    v = '0;
    base = mq.size() - KEY_W;
    for (int i = 0; i < KEY_W; i++) begin
      if (base + i >= 0) v[i] = mq[base+i];
    end
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge Clock or negedge RstBar);
      if (!RstBar) begin
        mq.delete();
        m_mode = M_ARMED; m_fails = 0; m_cd = 0; m_cdleft = 0; m_comp = 1'b0;
      end else begin
        bit u, c, s, hit;
        mmode_t old;
        u   = Select && UpdateEn;
        c   = Select && CaptureEN && !UpdateEn;
        s   = Select && ShiftEN && !UpdateEn && !CaptureEN;
        hit = (m_mode == M_ARMED) && (mq.size() == KEY_W) && (mkey() == KEY);
        old = m_mode;
        if (old == M_ARMED && u) begin
          if (m_comp) m_fails = 0;
          else if (mq.size() != 0) begin
            m_fails++;
            if (m_fails == MAX_FAIL) begin
              m_mode = M_COOL; m_cdleft = LOCKOUT_CYC; m_cd++;
            end
          end
        end else if (old == M_COOL) begin
          m_cdleft--;
          if (m_cdleft == 0) begin
            if (m_cd == MAX_LOCKOUT) m_mode = M_BLOCK;
            else begin m_mode = M_ARMED; m_fails = 0; end
          end
        end
        if (u || c) mq.delete();
        else if (s) begin
          mq.push_back(SI);
          if (mq.size() > KEY_W + 1) void'(mq.pop_front());
        end
        m_comp = hit && !u;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      logic [KEY_W-1:0] k;
      @(negedge Clock);
      k = mkey();
      chk("model_SO", 32'(SO), 32'(k[0]));
      chk("model_CompOut", 32'(CompOut), 32'(m_comp));
      chk("model_Locked", 32'(Locked), 32'(m_mode != M_ARMED));
      chk("model_FailCnt", 32'(FailCnt), m_fails);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic sel, input logic cap, input logic sh, input logic up,
                       input logic si);
    Select = sel; CaptureEN = cap; ShiftEN = sh; UpdateEn = up; SI = si;
    @(posedge Clock);
    #2;
    cyc_cnt++;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Capture, shift n bits LSB-first, then one idle cycle so CompOut settles.
  task automatic key_in(input logic [31:0] val, input int unsigned n);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, val[i]);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic upd();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic pulse_reset(input bit check);
    RstBar = 1'b0;
    #1;
    if (check) begin
      chk("rst_Locked", 32'(Locked), 32'd0);
      chk("rst_FailCnt", 32'(FailCnt), 32'd0);
      chk("rst_CompOut", 32'(CompOut), 32'd0);
      chk("rst_SO", 32'(SO), 32'd0);
    end
    @(posedge Clock);
    #2;
    cyc_cnt++;
    RstBar = 1'b1;
  endtask

  task automatic wait_unlock(output int unsigned waited);
    waited = 0;
    while (Locked && waited < 400) begin
      idle();
      waited++;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time budget at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int unsigned c0, waited, r, n;
    logic [31:0] v;

    repeat (3) @(posedge Clock);
    #2;
    chk("reset_SO", 32'(SO), 32'd0);
    chk("reset_CompOut", 32'(CompOut), 32'd0);
    chk("reset_Locked", 32'(Locked), 32'd0);
    chk("reset_FailCnt", 32'(FailCnt), 32'd0);
    RstBar = 1'b1;

    // T1: correct key
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < KEY_W; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, KEY[i]);
    chk("t1_comp_at_last_shift", 32'(CompOut), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_comp_after_shift", 32'(CompOut), 32'd1);
    upd();
    chk("t1_comp_after_update", 32'(CompOut), 32'd0);
    chk("t1_failcnt", 32'(FailCnt), 32'd0);

    // T2: three bad keys
    for (int unsigned a = 1; a <= 3; a++) begin
      key_in(32'h0, KEY_W);
      upd();
      chk("t2_failcnt", 32'(FailCnt), 32'(a));
    end
    chk("t2_locked", 32'(Locked), 32'd1);
    c0 = cyc_cnt;

    // T3: key ignored during cooldown, cooldown length, recovery
    key_in(32'(KEY), KEY_W);
    chk("t3_comp_in_cooldown", 32'(CompOut), 32'd0);
    upd();
    chk("t3_update_not_counted", 32'(FailCnt), 32'd3);
    wait_unlock(waited);
    chk("t3_cooldown_len", cyc_cnt - c0, LOCKOUT_CYC);
    chk("t3_failcnt_cleared", 32'(FailCnt), 32'd0);
    key_in(32'(KEY), KEY_W);
    chk("t3_comp_after_cooldown", 32'(CompOut), 32'd1);
    upd();

    // T4: two cooldowns end in BLOCKED
    pulse_reset(1'b0);
    repeat (3) begin key_in(32'h1234, KEY_W); upd(); end
    wait_unlock(waited);
    chk("t4_first_cooldown_len", waited, LOCKOUT_CYC);
    repeat (3) begin key_in(32'h0F0F, KEY_W); upd(); end
    wait_unlock(waited);
    chk("t4_blocked_locked", 32'(Locked), 32'd1);
    key_in(32'(KEY), KEY_W);
    chk("t4_blocked_comp", 32'(CompOut), 32'd0);
    upd();
    pulse_reset(1'b1);
    key_in(32'(KEY), KEY_W);
    chk("t4_comp_after_reset", 32'(CompOut), 32'd1);
    upd();

    // T5: wrong lengths
    key_in(32'h0001_0000 | 32'(KEY), KEY_W + 1);
    chk("t5_overlen_comp", 32'(CompOut), 32'd0);
    upd();
    chk("t5_overlen_fail", 32'(FailCnt), 32'd1);
    key_in(32'(KEY), KEY_W - 1);
    chk("t5_short_comp", 32'(CompOut), 32'd0);
    upd();
    chk("t5_short_fail", 32'(FailCnt), 32'd2);
    key_in(32'(KEY), KEY_W);
    upd();
    chk("t5_success_clears", 32'(FailCnt), 32'd0);

    // T6: empty update, unselected shift, update+shift collision
    key_in(32'h5555, KEY_W);
    upd();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    upd();
    chk("t6_empty_update", 32'(FailCnt), 32'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t6_upd_shift_empty", 32'(FailCnt), 32'd1);
    chk("t6_upd_shift_so", 32'(SO), 32'd0);
    key_in(32'(KEY), KEY_W);
    repeat (4) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t6_unsel_comp", 32'(CompOut), 32'd1);
    chk("t6_unsel_so", 32'(SO), 32'(KEY[0]));
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t6_upd_wins_fail", 32'(FailCnt), 32'd0);
    chk("t6_upd_wins_so", 32'(SO), 32'd0);
    chk("t6_upd_wins_comp", 32'(CompOut), 32'd0);

    // Random traffic
    pulse_reset(1'b0);
    for (int unsigned t = 0; t < 60; t++) begin
      r = $urandom_range(0, 19);
      if (r < 6) begin
        key_in(32'(KEY), KEY_W);
        upd();
      end else if (r < 12) begin
        v = $urandom;
        n = $urandom_range(KEY_W - 2, KEY_W + 2);
        key_in(v, n);
        if (v[0]) upd();
      end else if (r < 17) begin
        n = $urandom_range(1, 12);
        for (int unsigned j = 0; j < n; j++) begin
          v = $urandom;
          drive(v[0] | v[1], v[2] & v[3], v[4], v[5] & v[6] & v[7], v[8]);
        end
      end else if (r < 19) begin
        n = $urandom_range(1, 280);
        repeat (n) idle();
      end else begin
        pulse_reset(1'b0);
      end
    end
    repeat (2) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
